// File: rtl/u_adc_cap.sv
// rtl/u_adc_cap.sv - ADC capture block: arm/trigger/capture/done into a capture RAM.
// Optional level trigger enabled by defining ADC_THRESH_TRIG_EN.
module u_adc_cap #(
  parameter int         AW         = 13,
  parameter logic [1:0] SEL_RAM    = 2'b10,
  parameter logic [1:0] SEL_COMMON = 2'b00,
  parameter logic [1:0] SEL_REGS   = 2'b10
) (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic        i_cs,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_data,
  output logic [15:0] o_data,
  input  logic [13:0] i_adc_dat,
  input  logic        i_adc_ovr,
  input  logic        i_sync,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  tst
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPT, DONE} state_t;

  state_t          state, next;
  logic [2:0]      z_sync;
  logic            trig_src, tst_ramp, ovr_seen;
  logic [AW-1:0]   len, wr_ptr;
  logic [15:0]     decim, dec_cnt, ovr_cnt;
  logic [13:0]     ramp, sample;
  logic            reg_wr, arm_wr, abort_wr, trig_edge, store, start;
  logic [5:0]      off;
  logic            trig_lvl, lvl_trig, lvl_hit;
  logic [15:0]     ram [0:(2**AW)-1];
  logic [15:0]     ram_q, rd_q, rd_val;
  logic            sel_ram_q;
  logic            unused_addr0;

  assign unused_addr0 = i_addr[0];
  assign off       = i_addr[6:1];
  assign reg_wr    = i_cs & i_we & (i_addr[15:14] == SEL_COMMON) & (i_addr[13:12] == SEL_REGS);
  assign arm_wr    = reg_wr & (off == 6'd0) & i_data[0];
  assign abort_wr  = reg_wr & (off == 6'd0) & i_data[3];
  assign trig_edge = z_sync[1] & ~z_sync[2];
  assign sample    = tst_ramp ? ramp : i_adc_dat;
  assign tst       = wr_ptr[3:0];

`ifdef ADC_THRESH_TRIG_EN
  logic [13:0] thresh;
  assign lvl_hit = trig_lvl & ($signed(sample) >= $signed(thresh));
`else
  assign trig_lvl = 1'b0;
  assign lvl_trig = 1'b0;
  assign lvl_hit  = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_clr) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (arm_wr) next = ARMED;
      ARMED:   if (lvl_hit || !trig_src || trig_edge) next = CAPT;
      CAPT:    if (store && (wr_ptr == len)) next = DONE;
      DONE:    if (arm_wr) next = ARMED;
      default: next = IDLE;
    endcase
    if (abort_wr) next = IDLE;
  end

  always_comb begin
    o_busy = (state == ARMED) || (state == CAPT);
    o_done = (state == DONE);
    // the abort cycle stores nothing so wr_ptr stays where firmware saw it
    store  = (state == CAPT) && (dec_cnt == 16'd0) && !abort_wr;
    start  = arm_wr && !abort_wr && ((state == IDLE) || (state == DONE));
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      z_sync   <= '0;
      ramp     <= '0;
      trig_src <= 1'b0;
      tst_ramp <= 1'b0;
      len      <= '0;
      decim    <= '0;
      wr_ptr   <= '0;
      dec_cnt  <= '0;
      ovr_cnt  <= '0;
      ovr_seen <= 1'b0;
    end else begin
      z_sync <= {z_sync[1:0], i_sync};
      ramp   <= ramp + 14'd1;
      if (reg_wr) begin
        case (off)
          6'd0: begin
            trig_src <= i_data[1];
            tst_ramp <= i_data[2];
          end
          6'd1: len   <= i_data[AW-1:0];
          6'd2: decim <= i_data;
          default: ;
        endcase
      end
      if (start) begin
        wr_ptr   <= '0;
        dec_cnt  <= '0;
        ovr_cnt  <= '0;
        ovr_seen <= 1'b0;
      end else if ((state == CAPT) && !abort_wr) begin
        // >= keeps the counter sane if DECIM is lowered mid-capture
        dec_cnt <= (dec_cnt >= decim) ? 16'd0 : dec_cnt + 16'd1;
        if (store) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (i_adc_ovr) begin
            ovr_seen <= 1'b1;
            if (ovr_cnt != 16'hFFFF) ovr_cnt <= ovr_cnt + 16'd1;
          end
        end
      end
    end
  end

`ifdef ADC_THRESH_TRIG_EN
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      trig_lvl <= 1'b0;
      thresh   <= '0;
      lvl_trig <= 1'b0;
    end else begin
      if (reg_wr && (off == 6'd0)) trig_lvl <= i_data[4];
      if (reg_wr && (off == 6'd6)) thresh   <= i_data[13:0];
      if ((state == ARMED) && (next == CAPT)) lvl_trig <= lvl_hit;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (store) ram[wr_ptr] <= {i_adc_ovr, 1'b0, sample};
    ram_q <= ram[i_addr[AW:1]];
  end

  always_comb begin
    rd_val = 16'h1111;
    if (i_addr[15:14] == SEL_COMMON) begin
      rd_val = 16'h2222;
      if (i_addr[13:12] == SEL_REGS) begin
        case (off)
          6'd0: rd_val = {11'b0, trig_lvl, 1'b0, tst_ramp, trig_src, 1'b0};
          6'd1: rd_val = {{(16-AW){1'b0}}, len};
          6'd2: rd_val = decim;
          6'd3: rd_val = {11'b0, lvl_trig, ovr_seen, state == DONE, state == CAPT, state == ARMED};
          6'd4: rd_val = {{(16-AW){1'b0}}, wr_ptr};
          6'd5: rd_val = ovr_cnt;
`ifdef ADC_THRESH_TRIG_EN
          6'd6: rd_val = {{2{thresh[13]}}, thresh};
`endif
          default: rd_val = 16'h3333;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      rd_q      <= '0;
      sel_ram_q <= 1'b0;
    end else begin
      rd_q      <= rd_val;
      sel_ram_q <= (i_addr[15:14] == SEL_RAM);
    end
  end

  assign o_data = sel_ram_q ? ram_q : rd_q;

endmodule

// File: tb/tb_u_adc_cap.sv
// tb/tb_u_adc_cap.sv - self-checking bench for u_adc_cap: register table plus capture sequences.
module tb_u_adc_cap;

  logic        i_clk = 1'b0;
  logic        i_clr = 1'b1;
  logic        i_cs = 1'b0, i_we = 1'b0;
  logic [15:0] i_addr = '0, i_data = '0;
  logic [15:0] o_data;
  logic [13:0] i_adc_dat = '0;
  logic        i_adc_ovr = 1'b0, i_sync = 1'b0;
  logic        o_busy, o_done;
  logic [3:0]  tst;

  u_adc_cap dut (
    .i_clk(i_clk), .i_clr(i_clr), .i_cs(i_cs), .i_we(i_we), .i_addr(i_addr),
    .i_data(i_data), .o_data(o_data), .i_adc_dat(i_adc_dat), .i_adc_ovr(i_adc_ovr),
    .i_sync(i_sync), .o_busy(o_busy), .o_done(o_done), .tst(tst)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] exp;
  } vec_t;

  int          n_vec = 0, n_bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] words[16];

  function automatic logic [15:0] reg_a(input int o);
    return 16'h2000 + 16'(o * 2);
  endfunction

  function automatic logic [15:0] ram_a(input int k);
    return 16'h8000 + 16'(k * 2);
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    i_cs = 1'b1; i_we = 1'b1; i_addr = a; i_data = d;
    @(negedge i_clk);
    i_cs = 1'b0; i_we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    i_cs = 1'b1; i_addr = a;
    @(negedge i_clk);
    d = o_data;
    i_cs = 1'b0;
  endtask

  task automatic rd_exp(input string nm, input logic [15:0] a, input logic [15:0] e);
    logic [15:0] d;
    exp_q.push_back(e);
    rd(a, d);
    check(nm, d, exp_q.pop_front());
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (o_busy && n < 200) begin
      n++;
      @(negedge i_clk);
    end
  endtask

  task automatic wait_tst(input logic [3:0] v, input string nm);
    int n = 0;
    while (tst != v && n < 100) begin
      n++;
      @(negedge i_clk);
    end
    if (n >= 100) check(nm, {12'b0, tst}, {12'b0, v});
  endtask

  initial begin
    vec_t tbl[10];
    int   n;
    tbl[0] = '{reg_a(0), 16'h0000};
    tbl[1] = '{reg_a(1), 16'h0000};
    tbl[2] = '{reg_a(2), 16'h0000};
    tbl[3] = '{reg_a(3), 16'h0000};
    tbl[4] = '{reg_a(4), 16'h0000};
    tbl[5] = '{reg_a(5), 16'h0000};
`ifdef ADC_THRESH_TRIG_EN
    tbl[6] = '{reg_a(6), 16'h0000};
`else
    tbl[6] = '{reg_a(6), 16'h3333};
`endif
    tbl[7] = '{reg_a(7), 16'h3333};
    tbl[8] = '{16'hC000, 16'h1111};
    tbl[9] = '{16'h0000, 16'h2222};

    repeat (3) @(negedge i_clk);
    i_clr = 1'b0;
    check("reset_busy", {15'b0, o_busy}, 16'h0);
    check("reset_done", {15'b0, o_done}, 16'h0);
    check("reset_odata", o_data, 16'h0);
    for (int i = 0; i < 10; i++) rd_exp($sformatf("reg_tbl%0d", i), tbl[i].addr, tbl[i].exp);

    // ramp capture, 8 words, no decimation
    wr(reg_a(1), 16'd7);
    wr(reg_a(2), 16'd0);
    wr(reg_a(0), 16'h0005);
    count_busy(n);
    check("ramp_busy_cycles", 16'(n), 16'd9);
    check("ramp_done", {15'b0, o_done}, 16'h1);
    for (int k = 0; k < 8; k++) rd(ram_a(k), words[k]);
    for (int k = 1; k < 8; k++)
      check($sformatf("ramp_step%0d", k), (words[k] - words[k-1]) & 16'h3FFF, 16'd1);
    check("ramp_top_bits", words[3] & 16'hC000, 16'h0);
    rd_exp("ramp_wr_ptr", reg_a(4), 16'd8);
    rd_exp("ramp_status", reg_a(3), 16'h0004);
    rd_exp("ramp_conf", reg_a(0), 16'h0004);

    // decimated capture, 4 words spaced by 3
    wr(reg_a(1), 16'd3);
    wr(reg_a(2), 16'd2);
    wr(reg_a(0), 16'h0005);
    count_busy(n);
    check("decim_busy_cycles", 16'(n), 16'd11);
    for (int k = 0; k < 4; k++) rd(ram_a(k), words[k]);
    for (int k = 1; k < 4; k++)
      check($sformatf("decim_step%0d", k), (words[k] - words[k-1]) & 16'h3FFF, 16'd3);
    rd_exp("decim_wr_ptr", reg_a(4), 16'd4);

    // external sync trigger
    wr(reg_a(1), 16'd7);
    wr(reg_a(2), 16'd0);
    wr(reg_a(0), 16'h0007);
    repeat (20) @(negedge i_clk);
    check("sync_wait_busy", {15'b0, o_busy}, 16'h1);
    rd_exp("sync_wait_status", reg_a(3), 16'h0001);
    rd_exp("sync_wait_wr_ptr", reg_a(4), 16'd0);
    i_sync = 1'b1;
    n = 0;
    while (tst == 4'd0 && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("sync_first_write_lat", 16'(n), 16'd4);
    @(negedge i_clk);
    count_busy(n);
    check("sync_done", {15'b0, o_done}, 16'h1);
    rd_exp("sync_wr_ptr", reg_a(4), 16'd8);
    i_sync = 1'b0;

    // overrange on 5 stored samples, live ADC data
    wr(reg_a(1), 16'd15);
    wr(reg_a(0), 16'h0001);
    n = 0;
    while (!o_done && n < 100) begin
      i_adc_dat = 14'h100 + 14'(tst);
      i_adc_ovr = o_busy && (tst inside {4'd2, 4'd5, 4'd6, 4'd9, 4'd12});
      n++;
      @(negedge i_clk);
    end
    i_adc_ovr = 1'b0;
    check("ovr_done", {15'b0, o_done}, 16'h1);
    rd_exp("ovr_cnt", reg_a(5), 16'd5);
    rd_exp("ovr_status", reg_a(3), 16'h000C);
    for (int k = 0; k < 16; k++)
      rd_exp($sformatf("ovr_ram%0d", k), ram_a(k),
             {(k == 2 || k == 5 || k == 6 || k == 9 || k == 12), 1'b0, 14'h100 + 14'(k)});

    // abort mid-capture
    wr(reg_a(0), 16'h0005);
    wait_tst(4'd4, "abort_wait");
    wr(reg_a(0), 16'h000C);
    check("abort_busy", {15'b0, o_busy}, 16'h0);
    rd_exp("abort_status", reg_a(3), 16'h0000);
    rd_exp("abort_wr_ptr", reg_a(4), 16'd4);
    wr(reg_a(0), 16'h0009);
    check("abort_beats_arm", {15'b0, o_busy}, 16'h0);

    // reset mid-capture
    wr(reg_a(0), 16'h0005);
    wait_tst(4'd4, "clr_wait");
    i_clr = 1'b1;
    @(negedge i_clk);
    i_clr = 1'b0;
    check("clr_busy", {15'b0, o_busy}, 16'h0);
    check("clr_tst", {12'b0, tst}, 16'h0);
    check("clr_odata", o_data, 16'h0);
    rd_exp("clr_wr_ptr", reg_a(4), 16'd0);
    rd_exp("clr_len", reg_a(1), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/u_adc_cap.md
Name: u_adc_cap

Overview:
- Receive-side counterpart of the DAC output block: captures the parallel 14-bit ADC sample stream into an internal capture RAM.
- Control is through the same 16-bit register bus (i_cs/i_we/i_addr/i_data/o_data) used by the other sparrow peripherals.
- Supports arm/trigger/capture/done sequencing with optional sample decimation.
- The PS reads captured samples back through the RAM window.

Parameters:
- AW, 13, capture RAM address width; depth = 2^AW 16-bit words.
- SEL_RAM, 2'b10, i_addr[15:14] value selecting the capture-RAM window.
- SEL_COMMON, 2'b00, i_addr[15:14] value selecting the common register space.
- SEL_REGS, 2'b10, i_addr[13:12] value selecting this block's registers inside common space.

Ports:
- i_clk  in  1  sole clock: ADC sample clock, also used for the bus.
- i_clr  in  1  synchronous, active-high reset.
- i_cs  in  1  bus chip select.
- i_we  in  1  bus write strobe; a write occurs on any i_clk edge with i_cs&i_we.
- i_addr  in  16  bus byte address; i_addr[6:1] is the register offset, i_addr[AW:1] is the RAM word address.
- i_data  in  16  bus write data.
- o_data  out  16  bus read data, registered.
- i_adc_dat  in  14  ADC sample, valid every i_clk.
- i_adc_ovr  in  1  ADC overrange flag, aligned with i_adc_dat.
- i_sync  in  1  external trigger, asynchronous.
- o_busy  out  1  high in ARMED or CAPT.
- o_done  out  1  high in DONE.
- tst  out  4  wr_ptr[3:0].

Behaviour:
- Reset: state=IDLE; all registers, wr_ptr, ovr_cnt and o_data = 0; o_busy=o_done=0. RAM contents are not reset.
- Register offsets (i_addr[6:1]):
  - 0 CONF: bit0 ARM (self-clearing, reads 0), bit1 TRIG_SRC (0 = immediate, 1 = i_sync rising edge), bit2 TST_RAMP, bit3 ABORT (self-clearing, reads 0).
  - 1 LEN[AW-1:0]: capture count = LEN+1 samples.
  - 2 DECIM[15:0]: store one sample of every DECIM+1.
  - 3 STATUS (read-only): {12'b0, ovr_seen, done, capt, armed}.
  - 4 WR_PTR (read-only).
  - 5 OVR_CNT (read-only, saturates at 16'hFFFF).
  - Any other offset reads 16'h3333. Other common subspace reads 16'h2222. Unmapped [15:14] reads 16'h1111.
- Reads: o_data is valid the cycle after the address is presented (1-cycle latency), for both registers and RAM.
- Sync input: 3-stage shift register z_sync; trigger edge = z_sync[1]&~z_sync[2].
- State machine:
  - IDLE: ARM write -> ARMED. On this transition wr_ptr, dec_cnt, ovr_cnt and ovr_seen are cleared.
  - ARMED: TRIG_SRC=0 -> CAPT on the next cycle. TRIG_SRC=1 -> CAPT in the cycle after the trigger edge is detected. A trigger edge seen while in IDLE is ignored.
  - CAPT:
    - dec_cnt counts 0..DECIM. When dec_cnt==0, write word {i_adc_ovr, 1'b0, sample[13:0]} to RAM[wr_ptr] and increment wr_ptr.
    - sample = i_adc_dat, or a free-running 14-bit ramp when TST_RAMP=1.
    - After the write at wr_ptr==LEN -> DONE. This gives exactly LEN+1 words; LEN=0 captures 1 word.
    - The first stored sample is the one present in the first CAPT cycle.
  - DONE: holds until the next ARM write -> ARMED.
  - ABORT write in any state -> IDLE next cycle; RAM contents and wr_ptr are kept. ABORT wins over a simultaneous ARM.
- ovr_cnt: increments on each stored word whose ovr bit is 1 (saturating). ovr_seen is sticky until re-arm.
- RAM arbitration: the bus cannot write the capture RAM (write ignored). Bus reads are allowed in any state; a read during CAPT returns old or new data for the address being written in the same cycle.
- Register writes during CAPT:
  - LEN/DECIM changes take effect immediately.
  - If the new LEN is < wr_ptr, capture continues until wr_ptr wraps at 2^AW and reaches LEN again.
  - Firmware must not do this.
- Reset mid-capture: IDLE next cycle; the outputs above return to their reset values.

Optional Feature:
- Macro: ADC_THRESH_TRIG_EN.
- When defined:
  - Adds register offset 6 THRESH[13:0], signed two's complement.
  - Adds CONF bit4 TRIG_LVL. When TRIG_LVL=1 and the block is ARMED, the trigger fires when the signed sample >= THRESH; it goes to CAPT next cycle and has priority over TRIG_SRC.
  - STATUS bit4 = lvl_trig (the last trigger was a level trigger).
- When undefined: offset 6 reads 16'h3333, CONF bit4 is ignored, STATUS bit4 = 0.

Test Plan:
- Reset, then read all registers -> CONF/LEN/DECIM/STATUS/WR_PTR/OVR_CNT = 0; offset 7 = 16'h3333; [15:14]=2'b11 -> 16'h1111.
- LEN=7, DECIM=0, TST_RAMP=1, TRIG_SRC=0, ARM -> o_busy for 9 cycles, then o_done. RAM[0..7] hold consecutive ramp values. WR_PTR=8, STATUS=16'h0004.
- LEN=3, DECIM=2, ramp source, ARM -> RAM[0..3] = ramp values spaced by 3. Capture takes 10 CAPT cycles.
- TRIG_SRC=1, ARM, hold i_sync low 20 cycles (state stays ARMED, WR_PTR=0), then raise i_sync -> first write occurs 4 cycles after the raise; 8 words captured.
- Drive i_adc_ovr=1 on 5 stored samples, LEN=15 -> OVR_CNT=5, STATUS bit3=1, those RAM words have bit15=1.
- Mid-capture: ABORT at wr_ptr=4 -> state IDLE, WR_PTR=4. Repeat with i_clr pulsed at wr_ptr=4 -> WR_PTR=0, o_busy=0.
